fflop_gather: RTL and testbench

Receive-side width converter for the fflop valid/retry stream protocol. It consumes the narrow `Size`-bit beat stream produced by a chain of fflop stages and packs `Beats` consecutive beats into one wide word. It also honours an early-termination `last` sideband, so a partial word can be emitted. The wide word leaves through an fflop stage, so the block slots directly into existing retry pipelines.

---
 rtl/fflop_gather_pkg.sv | 17 +
 rtl/fflop.sv | 61 ++++++
 rtl/fflop_gather.sv | 83 ++++++++
 tb/tb_fflop_gather.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fflop_gather_pkg.sv
// Shared defaults and width helpers for the fflop beat gatherer.
package fflop_gather_pkg;

  localparam int unsigned DEF_SIZE  = 16;
  localparam int unsigned DEF_BEATS = 4;

  // Width of a beat-count field able to hold 1..beats.
  function automatic int unsigned beats_w(input int unsigned beats);
    return $clog2(beats + 1);
  endfunction

  // Width of a slice index running 0..beats-1.
  function automatic int unsigned cnt_w(input int unsigned beats);
    return $clog2(beats);
  endfunction

endpackage

// File: rtl/fflop.sv
// Two-entry valid/retry pipeline stage: head register plus one skid entry.
// dinRetry is the skid-occupied flag, so it is registered and input-independent.
module fflop #(
  parameter int unsigned Size = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Size-1:0] din,
  input  logic            dinValid,
  output logic            dinRetry,
  output logic [Size-1:0] q,
  output logic            qValid,
  input  logic            qRetry
);

  logic [Size-1:0] r_q;
  logic [Size-1:0] r_s;
  logic            r_qv;
  logic            r_sv;
  logic            w_push;
  logic            w_pop;
  logic            w_head_free;

  assign w_push      = dinValid && !r_sv;
  assign w_pop       = r_qv && !qRetry;
  assign w_head_free = !r_qv || w_pop;

  // Occupancy: a push lands in the head if it frees up, else in the skid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_qv <= 1'b0;
      r_sv <= 1'b0;
    end else if (w_head_free) begin
      if (r_sv) begin
        r_qv <= 1'b1;
        r_sv <= 1'b0;
      end else begin
        r_qv <= w_push;
      end
    end else if (w_push) begin
      r_sv <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_head_free) begin
      if (r_sv) begin
        r_q <= r_s;
      end else if (w_push) begin
        r_q <= din;
      end
    end else if (w_push) begin
      r_s <= din;
    end
  end

  assign dinRetry = r_sv;
  assign q        = r_q;
  assign qValid   = r_qv;

endmodule

// File: rtl/fflop_gather.sv
// Packs Beats narrow beats (or fewer, closed early by in1_last) into one wide
// word carrying its beat count in the MSBs, emitted through an fflop stage.
module fflop_gather
  import fflop_gather_pkg::*;
#(
  parameter int unsigned Size  = DEF_SIZE,
  parameter int unsigned Beats = DEF_BEATS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [Size-1:0]              in1,
  input  logic                         in1_valid,
  input  logic                         in1_last,
  output logic                         in1_retry,
  output logic [Size*Beats-1:0]        out1,
  output logic [$clog2(Beats+1)-1:0]   out1_beats,
  output logic                         out1_valid,
  input  logic                         out1_retry
);

  localparam int unsigned DW = Size * Beats;
  localparam int unsigned BW = beats_w(Beats);
  localparam int unsigned CW = cnt_w(Beats);

  logic [CW-1:0]    r_cnt;
  logic [DW-1:0]    r_acc;
  logic [DW-1:0]    w_merged;
  logic             w_accept;
  logic             w_last_slot;
  logic             w_complete;
  logic             w_din_retry;
  logic [BW+DW-1:0] w_din;
  logic [BW+DW-1:0] w_q;

  assign w_accept    = in1_valid && !w_din_retry;
  assign w_last_slot = (r_cnt == CW'(Beats - 1));
  assign w_complete  = w_accept && (w_last_slot || in1_last);

  // Slices below cnt come from the accumulator, cnt takes the live beat, the rest are zero.
  always_comb begin
    w_merged = '0;
    for (int unsigned i = 0; i < Beats; i++) begin
      if (i < 32'(r_cnt)) begin
        w_merged[i*Size +: Size] = r_acc[i*Size +: Size];
      end else if (i == 32'(r_cnt)) begin
        w_merged[i*Size +: Size] = in1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_complete) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + CW'(1);
      r_acc <= w_merged;
    end
  end

  assign w_din = {BW'(r_cnt) + BW'(1), w_merged};

  fflop #(
    .Size (BW + DW)
  ) u_out (
    .clk      (clk),
    .reset    (reset),
    .din      (w_din),
    .dinValid (w_complete),
    .dinRetry (w_din_retry),
    .q        (w_q),
    .qValid   (out1_valid),
    .qRetry   (out1_retry)
  );

  assign in1_retry  = w_din_retry;
  assign out1       = w_q[DW-1:0];
  assign out1_beats = w_q[BW+DW-1 -: BW];

endmodule

// File: tb/tb_fflop_gather.sv
// Self-checking bench for fflop_gather: directed cases plus randomized traffic
// checked against a queue-based model of completed words.
module tb_fflop_gather;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic [15:0] in1        = '0;
  logic        in1_valid  = 1'b0;
  logic        in1_last   = 1'b0;
  logic        in1_retry;
  logic [63:0] out1;
  logic [2:0]  out1_beats;
  logic        out1_valid;
  logic        out1_retry = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pop   = 0;

  // Model: words completed but not yet taken by the consumer, {beats, data}.
  logic [66:0] exp_q[$];
  logic [63:0] part   = '0;
  int          part_n = 0;

  fflop_gather #(.Size(16), .Beats(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in1        (in1),
    .in1_valid  (in1_valid),
    .in1_last   (in1_last),
    .in1_retry  (in1_retry),
    .out1       (out1),
    .out1_beats (out1_beats),
    .out1_valid (out1_valid),
    .out1_retry (out1_retry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model and output checker, evaluated between clock edges.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      part   = '0;
      part_n = 0;
    end else begin
      if (exp_q.size() > 0) begin
        chk("mon_valid", 128'(out1_valid), 128'(1));
        if (out1_valid) begin
          chk("mon_data", 128'(out1), 128'(exp_q[0][63:0]));
          chk("mon_beats", 128'(out1_beats), 128'(exp_q[0][66:64]));
        end
      end else begin
        chk("mon_idle", 128'(out1_valid), 128'(0));
        chk("mon_empty_retry", 128'(in1_retry), 128'(0));
      end
      if (exp_q.size() == 2) chk("mon_full_retry", 128'(in1_retry), 128'(1));
      if (out1_valid && !out1_retry && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        n_pop++;
      end
      if (in1_valid && !in1_retry) begin
        part[part_n*16 +: 16] = in1;
        part_n++;
        if (in1_last || part_n == 4) begin
          exp_q.push_back({3'(part_n), part});
          part   = '0;
          part_n = 0;
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; called at posedge+1.
  task automatic send_beat(input logic [15:0] d, input logic l);
    in1       = d;
    in1_last  = l;
    in1_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!in1_retry) begin
        sync();
        in1_valid = 1'b0;
        in1_last  = 1'b0;
        return;
      end
      sync();
    end
    chk("send_timeout", 128'(1), 128'(0));
    in1_valid = 1'b0;
    in1_last  = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [63:0] d, input logic [2:0] b);
    @(negedge clk);
    chk({tag, "_valid"}, 128'(out1_valid), 128'(1));
    chk({tag, "_data"}, 128'(out1), 128'(d));
    chk({tag, "_beats"}, 128'(out1_beats), 128'(b));
    sync();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    int  pop0;
    int  wait_n;
    logic acc;

    repeat (3) sync();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 128'(out1_valid), 128'(0));
    chk("rst_retry", 128'(in1_retry), 128'(0));
    sync();

    // Full word, output one cycle after the fourth beat.
    send_beat(16'h1111, 1'b0);
    send_beat(16'h2222, 1'b0);
    send_beat(16'h3333, 1'b0);
    send_beat(16'h4444, 1'b0);
    check_word("full", 64'h4444_3333_2222_1111, 3'd4);

    // Early last, single-beat last, and last on the fourth beat.
    send_beat(16'hAAAA, 1'b0);
    send_beat(16'hBBBB, 1'b1);
    check_word("last2", 64'h0000_0000_BBBB_AAAA, 3'd2);
    send_beat(16'h00FF, 1'b1);
    check_word("last1", 64'h0000_0000_0000_00FF, 3'd1);
    send_beat(16'h0001, 1'b0);
    send_beat(16'h0002, 1'b0);
    send_beat(16'h0003, 1'b0);
    send_beat(16'h0004, 1'b1);
    check_word("last4", 64'h0004_0003_0002_0001, 3'd4);
    repeat (2) sync();

    // Backpressure: 12 beats against a stalled consumer for 20 cycles.
    pop0       = n_pop;
    out1_retry = 1'b1;
    fork
      begin
        for (int i = 0; i < 12; i++) send_beat(16'(16'h0100 + i), 1'b0);
      end
      begin
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("bp_valid", 128'(out1_valid), 128'(1));
        chk("bp_retry", 128'(in1_retry), 128'(1));
        chk("bp_head", 128'(out1), 128'(64'h0103_0102_0101_0100));
        chk("bp_no_pop", 128'(n_pop - pop0), 128'(0));
        sync();
        out1_retry = 1'b0;
      end
    join
    repeat (20) sync();
    chk("bp_words_out", 128'(n_pop - pop0), 128'(3));

    // Bubbles mid-word.
    send_beat(16'hC001, 1'b0);
    send_beat(16'hC002, 1'b0);
    repeat (5) sync();
    send_beat(16'hC003, 1'b0);
    send_beat(16'hC004, 1'b0);
    check_word("bubble", 64'hC004_C003_C002_C001, 3'd4);

    // Reset with one word buffered and a partial word pending.
    out1_retry = 1'b1;
    for (int i = 0; i < 6; i++) send_beat(16'(16'hD000 + i), 1'b0);
    reset      = 1'b1;
    out1_retry = 1'b0;
    sync();
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_valid", 128'(out1_valid), 128'(0));
    chk("rstmid_retry", 128'(in1_retry), 128'(0));
    sync();
    send_beat(16'hE001, 1'b0);
    send_beat(16'hE002, 1'b0);
    send_beat(16'hE003, 1'b0);
    send_beat(16'hE004, 1'b0);
    check_word("rstmid_word", 64'hE004_E003_E002_E001, 3'd4);

    // Randomized traffic with bubbles, early last and consumer stalls.
    for (int c = 0; c < 1500; c++) begin
      out1_retry = ($urandom_range(0, 2) == 0);
      if (!in1_valid) begin
        in1      = 16'($urandom);
        in1_last = 1'($urandom);
        if ($urandom_range(0, 3) != 0) begin
          in1_valid = 1'b1;
          in1_last  = ($urandom_range(0, 4) == 0);
        end
      end
      @(negedge clk);
      acc = in1_valid && !in1_retry;
      sync();
      if (acc) in1_valid = 1'b0;
    end
    in1_valid  = 1'b0;
    in1_last   = 1'b0;
    out1_retry = 1'b0;
    send_beat(16'hBEEF, 1'b1);
    wait_n = 0;
    while ((exp_q.size() != 0 || out1_valid) && wait_n < 50) begin
      sync();
      wait_n++;
    end
    chk("drain_empty", 128'(exp_q.size()), 128'(0));
    chk("drain_valid", 128'(out1_valid), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
